// File: rtl/varcic_interp.sv
// Variable-rate CIC interpolator: low-rate comb chain, zero-stuffing, high-rate
// integrator chain, and rate-dependent rounding of the final integrator.
module varcic_interp #(
    parameter int STAGES    = 3,
    parameter int IN_WIDTH  = 18,
    parameter int OUT_WIDTH = 18,
    parameter int L2MI      = 6,
    parameter int ACC_WIDTH = IN_WIDTH + STAGES * L2MI
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [7:0]                  interpolation,
    input  logic                        out_strobe,
    output logic                        in_strobe,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    output logic signed [OUT_WIDTH-1:0] out_data
);

    localparam logic [L2MI-1:0]             PHASE_ZERO = {L2MI{1'b0}};
    localparam logic [L2MI-1:0]             PHASE_ONE  = {{(L2MI-1){1'b0}}, 1'b1};
    localparam logic signed [ACC_WIDTH-1:0] ACC_ZERO   = {ACC_WIDTH{1'b0}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX    = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_ZERO   = {OUT_WIDTH{1'b0}};
    localparam logic [7:0]                  SHIFT_BASE = 8'(IN_WIDTH - 1 - OUT_WIDTH);

    logic [L2MI-1:0]             r_phase;
    logic                        r_in_strobe;
    logic signed [ACC_WIDTH-1:0] r_comb  [STAGES];
    logic signed [ACC_WIDTH-1:0] r_last  [STAGES];
    logic signed [ACC_WIDTH-1:0] r_integ [STAGES];
    logic signed [OUT_WIDTH-1:0] r_out;

    logic                        w_phase_zero;
    logic                        w_wrap;
    logic signed [ACC_WIDTH-1:0] w_in_ext;
    logic signed [ACC_WIDTH-1:0] w_stuffed;
    logic [7:0]                  w_growth;
    logic [7:0]                  w_shamt;
    logic signed [ACC_WIDTH-1:0] w_shifted;
    logic signed [OUT_WIDTH-1:0] w_field;
    logic                        w_round;
    logic signed [OUT_WIDTH-1:0] w_rounded;

    // The >= compare lets the counter recover cleanly when the rate is lowered mid-run.
    assign w_phase_zero = (r_phase == PHASE_ZERO);
    assign w_wrap       = (8'(r_phase) >= (interpolation - 8'd1));
    assign w_in_ext     = {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
    assign w_stuffed    = w_phase_zero ? r_comb[STAGES-1] : ACC_ZERO;

    // Phase counter and one-cycle input request, both advanced only on output ticks.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_phase     <= PHASE_ZERO;
            r_in_strobe <= 1'b0;
        end else begin
            r_in_strobe <= out_strobe && w_phase_zero;
            if (out_strobe) begin
                r_phase <= w_wrap ? PHASE_ZERO : (r_phase + PHASE_ONE);
            end
        end
    end

    // Comb chain at the low rate; each stage differences the previous stage's prior output.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_comb[k] <= ACC_ZERO;
                r_last[k] <= ACC_ZERO;
            end
        end else if (r_in_strobe) begin
            r_comb[0] <= w_in_ext - r_last[0];
            r_last[0] <= w_in_ext;
            for (int k = 1; k < STAGES; k++) begin
                r_comb[k] <= r_comb[k-1] - r_last[k];
                r_last[k] <= r_comb[k-1];
            end
        end
    end

    // Integrator chain at the output rate; accumulators wrap freely.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_integ[k] <= ACC_ZERO;
            end
        end else if (out_strobe) begin
            r_integ[0] <= r_integ[0] + w_stuffed;
            for (int k = 1; k < STAGES; k++) begin
                r_integ[k] <= r_integ[k] + r_integ[k-1];
            end
        end
    end

    // Bit-growth select and round-half-up of the last integrator with positive saturation.
    always_comb begin
        w_growth  = 8'd11;
        w_shamt   = 8'd0;
        w_shifted = ACC_ZERO;
        w_field   = OUT_ZERO;
        w_round   = 1'b0;
        w_rounded = OUT_ZERO;
        case (interpolation)
            8'd5:    w_growth = 8'd5;
            8'd8:    w_growth = 8'd6;
            8'd10:   w_growth = 8'd7;
            8'd12:   w_growth = 8'd8;
            8'd20:   w_growth = 8'd9;
            8'd40:   w_growth = 8'd11;
            default: w_growth = 8'd11;
        endcase
        w_shamt   = w_growth + SHIFT_BASE;
        w_shifted = r_integ[STAGES-1] >>> w_shamt;
        w_field   = OUT_WIDTH'(w_shifted >>> 1);
        w_round   = w_shifted[0];
        if (w_round && (w_field == OUT_MAX)) begin
            w_rounded = OUT_MAX;
        end else begin
            w_rounded = w_field + {{(OUT_WIDTH-1){1'b0}}, w_round};
        end
    end

    // Registered output, refreshed every cycle from the rounded integrator value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= OUT_ZERO;
        end else begin
            r_out <= w_rounded;
        end
    end

    assign in_strobe = r_in_strobe;
    assign out_data  = r_out;

endmodule

// File: tb/tb_varcic_interp.sv
// Scoreboard bench for varcic_interp: a polyphase B-spline reference model predicts
// every output tick and every input request; a negedge monitor compares them.
module tb_varcic_interp;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic [7:0]         interpolation = 8'd5;
    logic               out_strobe = 1'b0;
    logic               in_strobe;
    logic signed [17:0] in_data = 18'sd0;
    logic signed [17:0] out_data;

    varcic_interp dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .interpolation (interpolation),
        .out_strobe    (out_strobe),
        .in_strobe     (in_strobe),
        .in_data       (in_data),
        .out_data      (out_data)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int                 cyc;
        bit                 chk;
        logic signed [17:0] val;
    } exp_t;

    exp_t out_q[$];
    int   strb_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    int R = 5;
    int G = 5;
    int h [0:127];
    int xs[$];
    int n_tick = 0;
    int phase_m = 0;
    bit out_chk = 1'b1;

    // impulse statistics gathered from the DUT's per-tick outputs
    bit     st_en = 1'b0;
    int     st_nz = 0;
    int     st_peak = 0;
    longint st_sum = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // h[k] = number of ways k splits into three terms in [0,R-1] (three cascaded boxes)
    function automatic void set_rate(input int r);
        R = r;
        case (r)
            5:       G = 5;
            8:       G = 6;
            10:      G = 7;
            12:      G = 8;
            20:      G = 9;
            default: G = 11;
        endcase
        for (int k = 0; k < 128; k++) h[k] = 0;
        for (int a = 0; a < r; a++)
            for (int b = 0; b < r; b++)
                for (int c = 0; c < r; c++)
                    h[a+b+c]++;
    endfunction

    // Output after tick n: zero-stuffed input filtered by h, delayed 3R+2 ticks, then rounded.
    function automatic logic signed [17:0] model_out(input int n);
        longint y = 0;
        longint q;
        int d;
        for (int k = 0; k <= 3*R-3; k++) begin
            d = n - 3*R - 2 - k;
            if (d >= 0 && (d % R) == 0 && (d / R) < xs.size())
                y += longint'(xs[d / R]) * longint'(h[k]);
        end
        q = (y + (longint'(1) <<< (G - 1))) >>> G;
        if (q > 131071) q = 131071;
        return 18'(q);
    endfunction

    task automatic step(input bit tick, input int din);
        @(posedge clock);
        #1;
        out_strobe = tick;
        if (tick) begin
            if (phase_m == 0) begin
                in_data = 18'(din);
                xs.push_back(din);
                strb_q.push_back(cyc + 1);
            end
            out_q.push_back('{cyc + 2, out_chk, model_out(n_tick)});
            n_tick++;
            phase_m = (phase_m >= R - 1) ? 0 : phase_m + 1;
        end
    endtask

    task automatic idle(input int k);
        repeat (k) step(1'b0, 0);
    endtask

    task automatic do_reset(input int r, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clock);
            #1;
            reset_n = 1'b0;
            out_strobe = ~out_strobe;
            out_q.delete();
            strb_q.delete();
            @(negedge clock);
            chk("rst_out_data", out_data, 0);
            chk("rst_in_strobe", in_strobe, 0);
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        out_strobe = 1'b0;
        in_data = 18'sd0;
        interpolation = 8'(r);
        set_rate(r);
        xs.delete();
        n_tick = 0;
        phase_m = 0;
        out_chk = 1'b1;
    endtask

    // Monitor: in_strobe must appear exactly where predicted; out_data checked per tick.
    always @(negedge clock) begin : monitor
        bit   exp_s;
        exp_t e;
        exp_s = 1'b0;
        if (strb_q.size() > 0 && strb_q[0] <= cyc) begin
            exp_s = (strb_q[0] == cyc);
            void'(strb_q.pop_front());
        end
        if (exp_s || in_strobe) chk("in_strobe", in_strobe, exp_s);
        while (out_q.size() > 0 && out_q[0].cyc <= cyc) begin
            e = out_q.pop_front();
            if (e.chk) chk("out_data", out_data, e.val);
            if (st_en) begin
                if (out_data != 0) st_nz++;
                st_sum += out_data;
                if (out_data > st_peak) st_peak = out_data;
            end
        end
    end

    int rates [6] = '{5, 8, 10, 12, 20, 40};

    initial begin
        set_rate(5);
        do_reset(5, 6);

        // impulse at R=5, ticks every third cycle
        st_en = 1'b1;
        for (int i = 0; i < 45; i++) begin
            step(1'b1, (i == 0) ? 4096 : 0);
            idle(2);
        end
        idle(3);
        st_en = 1'b0;
        chk("imp_nonzero", st_nz, 13);
        chk("imp_peak", st_peak, 2432);
        chk("imp_sum", st_sum, 16000);

        // DC at R=10, ticks every cycle
        do_reset(10, 1);
        for (int i = 0; i < 80; i++) step(1'b1, 1000);
        idle(3);
        chk("dc_r10", out_data, 781);

        // full-scale step at R=8 with random tick spacing
        do_reset(8, 1);
        for (int i = 0; i < 200; i++) begin
            step(1'b1, (i < 96) ? -131072 : 131071);
            idle($urandom_range(0, 2));
            if (i == 95) begin
                idle(3);
                chk("fs_neg", out_data, -131072);
            end
        end
        idle(3);
        chk("fs_pos", out_data, 131071);

        // random samples at every supported rate, random tick spacing
        foreach (rates[j]) begin
            do_reset(rates[j], 1);
            for (int i = 0; i < 8 * rates[j]; i++) begin
                step(1'b1, int'($urandom_range(0, 131071)) - 65536);
                if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            end
            idle(3);
        end

        // one-cycle reset with R=40 accumulators loaded, then DC 500
        do_reset(40, 1);
        for (int i = 0; i < 400; i++) step(1'b1, 500);
        idle(3);
        chk("dc_r40", out_data, 391);

        // lower the rate 20 -> 12 with phase at 15; the counter must wrap on the next tick
        do_reset(20, 1);
        for (int i = 0; i < 160; i++) step(1'b1, 1000);
        while (phase_m != 15) step(1'b1, 1000);
        idle(3);
        chk("dc_r20", out_data, 781);
        interpolation = 8'd12;
        R = 12;
        out_chk = 1'b0;
        for (int i = 0; i < 40; i++) step(1'b1, 1000);
        idle(3);
        // integrators keep the old-rate DC level, so the new gain is checked from reset
        do_reset(12, 1);
        for (int i = 0; i < 150; i++) step(1'b1, 1000);
        idle(3);
        chk("dc_r12", out_data, 563);

        // frozen block: no ticks, output holds
        idle(10);
        chk("frozen_hold", out_data, 563);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
